// File: rtl/dirty_range_arb_pkg.sv
// Shared encodings for the dirty-range arbiter: per-channel ownership states,
// scheduler states and the channel-index width helper.
package dirty_arb_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_DIRTY,
    CH_SEND,
    CH_SEND_DIRTY
  } ch_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_BUSY
  } sched_state_e;

  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dirty_range_arb_if.sv
// Write port and sender handshake bundle for dirty_range_arb; the arbiter
// takes the slave view, the write source / transmit engine the master view.
interface dirty_range_arb_if
  import dirty_arb_pkg::*;
#(
  parameter int AW  = 8,
  parameter int NCH = 4,
  parameter int CW  = chWidth(NCH)
);

  logic           wr_stb;
  logic [CW-1:0]  wr_ch;
  logic [AW-1:0]  wr_addr;
  logic           send_valid;
  logic           send_ready;
  logic [CW-1:0]  send_ch;
  logic [AW-1:0]  send_start;
  logic [AW-1:0]  send_end;
  logic           send_done;
  logic [NCH-1:0] modif;
  logic [NCH-1:0] modif2;

  modport slave (
    input  wr_stb, wr_ch, wr_addr, send_ready, send_done,
    output send_valid, send_ch, send_start, send_end, modif, modif2
  );

  modport master (
    output wr_stb, wr_ch, wr_addr, send_ready, send_done,
    input  send_valid, send_ch, send_start, send_end, modif, modif2
  );

endinterface

// File: rtl/dirty_range_arb_range_acc.sv
// Min/max address window accumulator for one channel. A clear in the same
// cycle as a write restarts the window at the written address.
module range_acc #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  output logic          valid_o,
  output logic [AW-1:0] min_o,
  output logic [AW-1:0] max_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] min_q, min_d;
  logic [AW-1:0] max_q, max_d;

  always_comb begin
    valid_d = valid_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end
    if (wr_i) begin
      if (clr_i || !valid_q) begin
        valid_d = 1'b1;
        min_d   = addr_i;
        max_d   = addr_i;
      end else begin
        if (addr_i < min_q) min_d = addr_i;
        if (addr_i > max_q) max_d = addr_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      valid_q <= valid_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign valid_o = valid_q;
  assign min_o   = min_q;
  assign max_o   = max_q;

endmodule

// File: rtl/dirty_range_arb.sv
// Per-channel dirty-window tracking with a round-robin scheduler that offers
// one snapshotted window at a time to a single downstream sender.
module dirty_range_arb
  import dirty_arb_pkg::*;
#(
  parameter int AW  = 8,
  parameter int NCH = 4
) (
  input logic             clk,
  input logic             rst,
  dirty_range_arb_if.slave bus
);

  localparam int CW = chWidth(NCH);

  ch_state_e     chState_q [NCH];
  ch_state_e     chState_d [NCH];
  logic [NCH-1:0] wrHit;
  logic [NCH-1:0] accClr;
  logic [NCH-1:0] accValid;
  logic [AW-1:0]  accMin [NCH];
  logic [AW-1:0]  accMax [NCH];

  sched_state_e  sched_q, sched_d;
  logic [CW-1:0] lastCh_q, lastCh_d;
  logic [CW-1:0] snapCh_q, snapCh_d;
  logic [AW-1:0] snapStart_q, snapStart_d;
  logic [AW-1:0] snapEnd_q, snapEnd_d;

  logic          pickFound;
  logic [CW-1:0] pickCh;
  logic          doneEv;

  assign doneEv = (sched_q == S_BUSY) && bus.send_done;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign wrHit[c]  = bus.wr_stb && (bus.wr_ch == CW'(c));
    assign accClr[c] = (sched_q == S_IDLE) && pickFound && (pickCh == CW'(c));

    range_acc #(.AW(AW)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (accClr[c]),
      .wr_i   (wrHit[c]),
      .addr_i (bus.wr_addr),
      .valid_o(accValid[c]),
      .min_o  (accMin[c]),
      .max_o  (accMax[c])
    );

    assign bus.modif[c]  = (chState_q[c] != CH_IDLE);
    assign bus.modif2[c] = (chState_q[c] == CH_SEND_DIRTY);
  end

  // Round-robin search starts just after the last served channel and wraps.
  always_comb begin
    int idx;
    idx       = 0;
    pickFound = 1'b0;
    pickCh    = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(lastCh_q) + i) % NCH;
      if (!pickFound && chState_q[idx[CW-1:0]] == CH_DIRTY) begin
        pickFound = 1'b1;
        pickCh    = idx[CW-1:0];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      chState_d[c] = chState_q[c];
      case (chState_q[c])
        CH_IDLE:       if (wrHit[c]) chState_d[c] = CH_DIRTY;
        CH_DIRTY:      if (accClr[c]) chState_d[c] = wrHit[c] ? CH_SEND_DIRTY : CH_SEND;
        CH_SEND: begin
          if (doneEv)        chState_d[c] = wrHit[c] ? CH_DIRTY : CH_IDLE;
          else if (wrHit[c]) chState_d[c] = CH_SEND_DIRTY;
        end
        CH_SEND_DIRTY: if (doneEv) chState_d[c] = CH_DIRTY;
        default:       chState_d[c] = CH_IDLE;
      endcase
    end
  end

  always_comb begin
    sched_d     = sched_q;
    lastCh_d    = lastCh_q;
    snapCh_d    = snapCh_q;
    snapStart_d = snapStart_q;
    snapEnd_d   = snapEnd_q;
    case (sched_q)
      S_IDLE: begin
        if (pickFound) begin
          snapCh_d    = pickCh;
          snapStart_d = accMin[pickCh];
          snapEnd_d   = accMax[pickCh];
          lastCh_d    = pickCh;
          sched_d     = S_OFFER;
        end
      end
      S_OFFER: if (bus.send_ready) sched_d = S_BUSY;
      S_BUSY:  if (bus.send_done)  sched_d = S_IDLE;
      default: sched_d = S_IDLE;
    endcase
  end

  // lastCh resets to the top channel so channel 0 is served first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) chState_q[c] <= CH_IDLE;
      sched_q     <= S_IDLE;
      lastCh_q    <= CW'(NCH - 1);
      snapCh_q    <= '0;
      snapStart_q <= '0;
      snapEnd_q   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) chState_q[c] <= chState_d[c];
      sched_q     <= sched_d;
      lastCh_q    <= lastCh_d;
      snapCh_q    <= snapCh_d;
      snapStart_q <= snapStart_d;
      snapEnd_q   <= snapEnd_d;
    end
  end

  assign bus.send_valid = (sched_q == S_OFFER);
  assign bus.send_ch    = snapCh_q;
  assign bus.send_start = snapStart_q;
  assign bus.send_end   = snapEnd_q;

endmodule

// File: tb/tb_dirty_range_arb.sv
// Directed bench for dirty_range_arb: a window/ownership model checked every
// cycle plus literal expectations at the key points of each scenario.
module tb_dirty_range_arb;

  localparam int AW  = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dirty_range_arb_if #(.AW(AW), .NCH(NCH)) bus ();
  dirty_range_arb #(.AW(AW), .NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  dirty_range_arb_if #(.AW(AW), .NCH(3)) bus3 ();
  dirty_range_arb #(.AW(AW), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int total = 0;
  int bad   = 0;

  // Model: per-channel window, which channel the sender owns, handshake phase.
  bit            mV   [NCH];
  logic [AW-1:0] mMin [NCH];
  logic [AW-1:0] mMax [NCH];
  int            mOwner = -1;
  int            mPhase = 0;
  int            mLast  = NCH - 1;
  int            mSnapCh = 0;
  logic [AW-1:0] mSnapS = '0;
  logic [AW-1:0] mSnapE = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mV[c] = 1'b0; mMin[c] = '0; mMax[c] = '0;
    end
    mOwner = -1; mPhase = 0; mLast = NCH - 1;
    mSnapCh = 0; mSnapS = '0; mSnapE = '0;
  endtask

  task automatic modelStep();
    int p;
    int k;
    int c;
    p = -1;
    if (mPhase == 0) begin
      for (int i = 1; i <= NCH; i++) begin
        k = (mLast + i) % NCH;
        if (p < 0 && mV[k]) p = k;
      end
      if (p >= 0) begin
        mSnapCh = p; mSnapS = mMin[p]; mSnapE = mMax[p];
        mV[p] = 1'b0; mOwner = p; mLast = p; mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (bus.send_ready) mPhase = 2;
    end else if (bus.send_done) begin
      mOwner = -1; mPhase = 0;
    end
    if (bus.wr_stb && int'(bus.wr_ch) < NCH) begin
      c = int'(bus.wr_ch);
      if (!mV[c]) begin
        mV[c] = 1'b1; mMin[c] = bus.wr_addr; mMax[c] = bus.wr_addr;
      end else begin
        if (bus.wr_addr < mMin[c]) mMin[c] = bus.wr_addr;
        if (bus.wr_addr > mMax[c]) mMax[c] = bus.wr_addr;
      end
    end
  endtask

  task automatic checkAgainstModel();
    logic [NCH-1:0] eM;
    logic [NCH-1:0] eM2;
    for (int c = 0; c < NCH; c++) begin
      eM[c]  = mV[c] || (mOwner == c);
      eM2[c] = mV[c] && (mOwner == c);
    end
    checkOutput("model send_valid", bus.send_valid, mPhase == 1);
    checkOutput("model send_ch", bus.send_ch, mSnapCh);
    checkOutput("model send_start", bus.send_start, mSnapS);
    checkOutput("model send_end", bus.send_end, mSnapE);
    checkOutput("model modif", bus.modif, eM);
    checkOutput("model modif2", bus.modif2, eM2);
  endtask

  always @(posedge clk) begin
    if (rst) modelReset();
    else     modelStep();
  end

  always @(negedge clk) begin
    if (!rst) checkAgainstModel();
  end

  // Drives one cycle of inputs and returns at the following falling edge.
  task automatic applyStimulus(input logic stb, input int ch, input logic [AW-1:0] addr,
                               input logic rdy, input logic done);
    bus.wr_stb     = stb;
    bus.wr_ch      = 2'(ch);
    bus.wr_addr    = addr;
    bus.send_ready = rdy;
    bus.send_done  = done;
    @(negedge clk);
  endtask

  task automatic waitOffer(input string name);
    int n;
    n = 0;
    while (!bus.send_valid && n < 8) begin
      applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    checkOutput({name, " offer"}, bus.send_valid, 1);
  endtask

  task automatic runRoundRobin();
    int since;
    int got[$];
    int expOrder[5];
    logic stb;
    int ch;
    logic [AW-1:0] addr;
    logic doneNow;
    expOrder = '{0, 2, 3, 0, 3};
    since = -1;
    for (int it = 0; it < 30; it++) begin
      stb = 1'b1; ch = 0; addr = 8'h00;
      case (it)
        0:  begin ch = 0; addr = 8'h11; end
        1:  begin ch = 2; addr = 8'h22; end
        2:  begin ch = 3; addr = 8'h33; end
        13: begin ch = 3; addr = 8'h44; end
        14: begin ch = 0; addr = 8'h55; end
        default: stb = 1'b0;
      endcase
      if (since >= 0) since++;
      doneNow = (since == 3);
      if (doneNow) since = -1;
      if (bus.send_valid) begin
        got.push_back(int'(bus.send_ch));
        since = 0;
      end
      applyStimulus(stb, ch, addr, 1'b1, doneNow);
    end
    checkOutput("rr count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) checkOutput($sformatf("rr order %0d", i), got[i], expOrder[i]);
    end
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bus.wr_stb = 1'b0; bus.wr_ch = '0; bus.wr_addr = '0;
    bus.send_ready = 1'b0; bus.send_done = 1'b0;
    bus3.wr_stb = 1'b0; bus3.wr_ch = '0; bus3.wr_addr = '0;
    bus3.send_ready = 1'b0; bus3.send_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset send_valid", bus.send_valid, 0);
    checkOutput("reset send_ch", bus.send_ch, 0);
    checkOutput("reset send_start", bus.send_start, 0);
    checkOutput("reset send_end", bus.send_end, 0);
    checkOutput("reset modif", bus.modif, 0);
    checkOutput("reset modif2", bus.modif2, 0);
    repeat (20) applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle no offer", bus.send_valid, 0);

    // Single channel: ch1 accumulates while ch0 holds the sender.
    applyStimulus(1'b1, 0, 8'h01, 1'b0, 1'b0);
    waitOffer("A0");
    checkOutput("A0 ch", bus.send_ch, 0);
    checkOutput("A0 start", bus.send_start, 8'h01);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 8'h7F, 1'b0, 1'b0);
    checkOutput("A busy modif", bus.modif, 4'b0011);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    waitOffer("A1");
    checkOutput("A1 ch", bus.send_ch, 1);
    checkOutput("A1 start", bus.send_start, 8'h10);
    checkOutput("A1 end", bus.send_end, 8'h7F);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    checkOutput("A1 done modif", bus.modif, 0);

    // Write during transfer.
    applyStimulus(1'b1, 0, 8'h20, 1'b0, 1'b0);
    waitOffer("B0");
    checkOutput("B0 ch", bus.send_ch, 0);
    checkOutput("B0 start", bus.send_start, 8'h20);
    checkOutput("B0 end", bus.send_end, 8'h20);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 0, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 8'h30, 1'b0, 1'b0);
    checkOutput("B modif2", bus.modif2, 4'b0001);
    checkOutput("B snap start", bus.send_start, 8'h20);
    checkOutput("B snap end", bus.send_end, 8'h20);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    waitOffer("B1");
    checkOutput("B1 start", bus.send_start, 8'h05);
    checkOutput("B1 end", bus.send_end, 8'h30);
    checkOutput("B1 modif2", bus.modif2, 0);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);

    runRoundRobin();

    // Boundaries and stray handshake pulses.
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);
    checkOutput("stray done valid", bus.send_valid, 0);
    checkOutput("stray done modif", bus.modif, 0);
    applyStimulus(1'b1, 2, 8'h80, 1'b0, 1'b0);
    waitOffer("D0");
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    checkOutput("done in offer", bus.send_valid, 1);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    waitOffer("D1");
    checkOutput("D1 ch", bus.send_ch, 1);
    checkOutput("D1 start", bus.send_start, 8'h00);
    checkOutput("D1 end", bus.send_end, 8'hFF);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);

    // Reset while ch2 is SEND_DIRTY.
    applyStimulus(1'b1, 2, 8'h12, 1'b0, 1'b0);
    waitOffer("E0");
    checkOutput("E0 ch", bus.send_ch, 2);
    applyStimulus(1'b0, 0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 2, 8'h34, 1'b0, 1'b0);
    checkOutput("E modif2", bus.modif2, 4'b0100);
    rst = 1'b1;
    #1;
    checkOutput("E rst valid", bus.send_valid, 0);
    checkOutput("E rst modif", bus.modif, 0);
    checkOutput("E rst modif2", bus.modif2, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 8'h00, 1'b0, 1'b0);
    checkOutput("E post valid", bus.send_valid, 0);
    checkOutput("E post modif", bus.modif, 0);

    // Three-channel instance: out-of-range channel index is dropped.
    bus3.wr_stb = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_addr = 8'h55;
    @(negedge clk);
    bus3.wr_stb = 1'b0;
    checkOutput("nch3 ignored modif", bus3.modif, 0);
    repeat (3) @(negedge clk);
    checkOutput("nch3 ignored valid", bus3.send_valid, 0);
    bus3.wr_stb = 1'b1; bus3.wr_ch = 2'd2; bus3.wr_addr = 8'h66;
    @(negedge clk);
    bus3.wr_stb = 1'b0;
    checkOutput("nch3 ch2 modif", bus3.modif, 3'b100);
    @(negedge clk);
    checkOutput("nch3 ch2 valid", bus3.send_valid, 1);
    checkOutput("nch3 ch2 ch", bus3.send_ch, 2);
    checkOutput("nch3 ch2 start", bus3.send_start, 8'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
